// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the RISC-V core.
//   Registers the decode-stage control bundle and operands for execute,
//   detects load-use hazards against the instruction in EX, inserts bubbles
//   on hazard or branch flush, and holds a sticky halt once HALT has spent
//   one cycle in EX.
// Ports:
//   clk, reset          - clock; synchronous active-low reset
//   id_*                - controller outputs and decoded operands/fields
//   flush               - taken branch/jump in EX, squash decode instruction
//   ex_*                - registered copies of id_* (bubble clears controls)
//   ex_valid            - EX holds a real instruction
//   stall               - hold PC and IF/ID this cycle (combinational)
//   halted              - core halted (sticky until reset)
// Optional (macro ID_EX_PERF_CNT_EN):
//   perf_stall_cnt, perf_flush_cnt - saturating 32-bit event counters
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_ALUSrc,
  input  logic              id_MemtoReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_jalr_selec,
  input  logic [1:0]        id_ALUOp,
  input  logic [1:0]        id_RW_selec,
  input  logic              id_halt,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              flush,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_jalr_selec,
  output logic [1:0]        ex_ALUOp,
  output logic [1:0]        ex_RW_selec,
  output logic              ex_halt,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_valid,
  output logic              stall,
  output logic              halted
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state, state_nxt;
  logic   hazard;
  logic   bubble;

  // Both source fields are compared regardless of instruction format; a false
  // stall on I/U/J formats is harmless and deterministic.
  assign hazard = ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign halted = (state == HALTED);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    bubble    = 1'b0;
    case (state)
      RUN: begin
        stall = hazard & ~flush;
        if (ex_valid & ex_halt) begin
          state_nxt = HALTED;
          bubble    = 1'b1;
        end else if (flush | hazard) begin
          bubble = 1'b1;
        end
      end
      HALTED: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        bubble    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= RUN;
      ex_ALUSrc     <= 1'b0;
      ex_MemtoReg   <= 1'b0;
      ex_RegWrite   <= 1'b0;
      ex_MemRead    <= 1'b0;
      ex_MemWrite   <= 1'b0;
      ex_Branch     <= 1'b0;
      ex_jalr_selec <= 1'b0;
      ex_ALUOp      <= '0;
      ex_RW_selec   <= '0;
      ex_halt       <= 1'b0;
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_funct7     <= '0;
    end else begin
      state         <= state_nxt;
      ex_ALUSrc     <= id_ALUSrc     & ~bubble;
      ex_MemtoReg   <= id_MemtoReg   & ~bubble;
      ex_RegWrite   <= id_RegWrite   & ~bubble;
      ex_MemRead    <= id_MemRead    & ~bubble;
      ex_MemWrite   <= id_MemWrite   & ~bubble;
      ex_Branch     <= id_Branch     & ~bubble;
      ex_jalr_selec <= id_jalr_selec & ~bubble;
      ex_ALUOp      <= bubble ? 2'b00 : id_ALUOp;
      ex_RW_selec   <= bubble ? 2'b00 : id_RW_selec;
      ex_halt       <= id_halt       & ~bubble;
      ex_valid      <= ~bubble;
      // Data fields load even on a bubble; only controls are squashed.
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_funct3     <= id_funct3;
      ex_funct7     <= id_funct7;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (state == RUN) begin
      if (flush && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (hazard && !flush && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized self-checking bench for id_ex_stage against a
// cycle-level reference model of the pipeline register, hazard and halt rules.
module tb_id_ex_stage;

  typedef struct packed {
    logic        alusrc, memtoreg, regwrite, memread, memwrite, branch, jalr;
    logic [1:0]  aluop, rwsel;
    logic        halt;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } instr_t;

  logic clk = 1'b0;
  logic reset, flush;
  instr_t cur;

  logic        ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic        ex_Branch, ex_jalr_selec, ex_halt, ex_valid, stall, halted;
  logic [1:0]  ex_ALUOp, ex_RW_selec;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_ALUSrc(cur.alusrc), .id_MemtoReg(cur.memtoreg), .id_RegWrite(cur.regwrite),
    .id_MemRead(cur.memread), .id_MemWrite(cur.memwrite), .id_Branch(cur.branch),
    .id_jalr_selec(cur.jalr), .id_ALUOp(cur.aluop), .id_RW_selec(cur.rwsel),
    .id_halt(cur.halt), .id_pc(cur.pc), .id_rs1_data(cur.rs1d), .id_rs2_data(cur.rs2d),
    .id_imm(cur.imm), .id_rs1(cur.rs1), .id_rs2(cur.rs2), .id_rd(cur.rd),
    .id_funct3(cur.f3), .id_funct7(cur.f7), .flush(flush),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_jalr_selec(ex_jalr_selec), .ex_ALUOp(ex_ALUOp), .ex_RW_selec(ex_RW_selec),
    .ex_halt(ex_halt), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_valid(ex_valid),
    .stall(stall), .halted(halted)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: what EX should hold after the last edge.
  instr_t      m;
  logic        m_valid, m_halted;
  logic [31:0] m_scnt, m_fcnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    t = '0;
    t.alusrc = 1'($urandom);   t.memtoreg = 1'($urandom); t.regwrite = 1'($urandom);
    t.memread = ($urandom_range(0, 2) == 0); t.memwrite = 1'($urandom);
    t.branch = 1'($urandom);   t.jalr = 1'($urandom);
    t.aluop = 2'($urandom);    t.rwsel = 2'($urandom);
    t.halt = ($urandom_range(0, 49) == 0);
    t.pc = $urandom; t.rs1d = $urandom; t.rs2d = $urandom; t.imm = $urandom;
    t.rs1 = 5'($urandom_range(0, 3)); t.rs2 = 5'($urandom_range(0, 3));
    t.rd = 5'($urandom_range(0, 3));
    t.f3 = 3'($urandom); t.f7 = 7'($urandom);
    return t;
  endfunction

  function automatic instr_t squash(input instr_t t);
    instr_t b;
    b = t;
    {b.alusrc, b.memtoreg, b.regwrite, b.memread, b.memwrite, b.branch, b.jalr} = '0;
    b.aluop = '0; b.rwsel = '0; b.halt = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic check_outputs();
    check("ex_valid", 64'(ex_valid), 64'(m_valid));
    check("halted", 64'(halted), 64'(m_halted));
    check("ctrl",
      64'({ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
           ex_jalr_selec, ex_ALUOp, ex_RW_selec, ex_halt}),
      64'({m.alusrc, m.memtoreg, m.regwrite, m.memread, m.memwrite, m.branch,
           m.jalr, m.aluop, m.rwsel, m.halt}));
    if (!m_halted) begin
      check("pc", 64'(ex_pc), 64'(m.pc));
      check("operands", {ex_rs1_data, ex_rs2_data}, {m.rs1d, m.rs2d});
      check("imm", 64'(ex_imm), 64'(m.imm));
      check("fields", 64'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7}),
                      64'({m.rs1, m.rs2, m.rd, m.f3, m.f7}));
    end
`ifdef ID_EX_PERF_CNT_EN
    check("perf_cnt", {perf_stall_cnt, perf_flush_cnt}, {m_scnt, m_fcnt});
`endif
  endtask

  // One clock: drive inputs at the negedge, check stall, advance the model,
  // then check registered outputs at the following negedge.
  task automatic cycle(input instr_t t, input logic f, input logic rst, output logic exp_stall);
    logic hz;
    cur = t; flush = f; reset = rst;
    #1;
    hz = m_valid && m.memread && (m.rd != 0) && (m.rd == t.rs1 || m.rd == t.rs2);
    exp_stall = m_halted ? 1'b1 : (hz && !f);
    check("stall", 64'(stall), 64'(exp_stall));
    if (!rst) begin
      m = '0; m_valid = 0; m_halted = 0; m_scnt = 0; m_fcnt = 0;
    end else if (m_halted) begin
      m = squash(t); m_valid = 0;
    end else begin
      if (f) m_fcnt = sat_inc(m_fcnt);
      else if (hz) m_scnt = sat_inc(m_scnt);
      if (m_valid && m.halt) begin
        m_halted = 1; m = squash(t); m_valid = 0;
      end else if (f || hz) begin
        m = squash(t); m_valid = 0;
      end else begin
        m = t; m_valid = 1;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    instr_t t, held;
    logic s, was_stall;
    m = '0; m_valid = 0; m_halted = 0; m_scnt = 0; m_fcnt = 0;
    cur = rand_instr(); flush = 0; reset = 0;
    @(negedge clk);

    // Reset held for two cycles with random decode activity.
    cycle(rand_instr(), 1'b1, 1'b0, s);
    cycle(rand_instr(), 1'b0, 1'b0, s);
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_pc", 64'(ex_pc), 64'd0);
    t = rand_instr(); t.halt = 0; t.memread = 0; t.regwrite = 1; t.rd = 5'd5;
    cycle(t, 1'b0, 1'b1, s);
    check("post_rst_rw_rd", 64'({ex_RegWrite, ex_rd, ex_valid}), 64'({1'b1, 5'd5, 1'b1}));

    // Load-use: lw x3 in EX, add x4,x3,x1 in decode.
    t = rand_instr(); t.halt = 0; t.memread = 1; t.rd = 5'd3;
    cycle(t, 1'b0, 1'b1, s);
    t = rand_instr(); t.halt = 0; t.memread = 0; t.rs1 = 5'd3; t.rs2 = 5'd1; t.rd = 5'd4;
    cycle(t, 1'b0, 1'b1, s);
    check("lu_stall", 64'(s), 64'd1);
    check("lu_bubble", 64'(ex_valid), 64'd0);
    cycle(t, 1'b0, 1'b1, s);
    check("lu_release", 64'({s, ex_valid, ex_rs1}), 64'({1'b0, 1'b1, 5'd3}));

    // Load with rd = x0 never stalls.
    held = rand_instr(); held.halt = 0; held.memread = 1; held.rd = 5'd0;
    cycle(held, 1'b0, 1'b1, s);
    t.rs1 = 5'd0;
    cycle(t, 1'b0, 1'b1, s);
    check("x0_nostall", 64'(s), 64'd0);

    // Flush masks the hazard.
    held.rd = 5'd3;
    cycle(held, 1'b0, 1'b1, s);
    t.rs1 = 5'd3;
    cycle(t, 1'b1, 1'b1, s);
    check("flush_vs_hz", 64'({s, ex_valid}), 64'({1'b0, 1'b0}));

    // Flushed halt never halts.
    t = rand_instr(); t.halt = 1;
    cycle(t, 1'b1, 1'b1, s);
    check("flushed_halt", 64'(ex_halt), 64'd0);
    t = rand_instr(); t.halt = 0;
    cycle(t, 1'b0, 1'b1, s);
    check("flushed_halt_run", 64'(halted), 64'd0);

    // Halt reaches EX, then the core stays halted until reset.
    t = rand_instr(); t.halt = 1; t.memread = 0;
    cycle(t, 1'b0, 1'b1, s);
    check("halt_in_ex", 64'({ex_halt, ex_valid}), 64'({1'b1, 1'b1}));
    cycle(rand_instr(), 1'b0, 1'b1, s);
    check("halted_set", 64'({halted, stall}), 64'({1'b1, 1'b1}));
    for (int i = 0; i < 4; i++) cycle(rand_instr(), 1'($urandom), 1'b1, s);
    check("halted_bubble", 64'(ex_valid), 64'd0);
    cycle(rand_instr(), 1'b0, 1'b0, s);
    check("halt_reset", 64'({halted, stall}), 64'd0);

`ifdef ID_EX_PERF_CNT_EN
    // Counter saturation from a preset value.
    t = rand_instr(); t.halt = 0; t.memread = 1; t.rd = 5'd2;
    cycle(t, 1'b0, 1'b1, s);
    force dut.perf_stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.perf_stall_cnt;
    m_scnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      t.rs1 = 5'd2;
      cycle(t, 1'b0, 1'b1, s);
      t.memread = 1;
      cycle(t, 1'b0, 1'b1, s);
    end
    check("stall_cnt_sat", 64'(perf_stall_cnt), 64'hFFFF_FFFF);
`endif

    // Randomized run; a stalled decode instruction is re-presented next cycle.
    was_stall = 0;
    held = rand_instr();
    for (int i = 0; i < 3000; i++) begin
      if (!(was_stall && !m_halted)) held = rand_instr();
      cycle(held, ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) != 0), was_stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
